// File: rtl/mac_dot_sequencer.sv
// Dot-product sequencer: buffers operand pairs, streams them into a saturating
// 14x14 MAC, counts completions and returns the saturated 28-bit sum.
//
// state | meaning
// IDLE  | operand writes accepted, waiting for start
// CLEAR | MAC held in clear for two cycles
// ISSUE | one operand pair per cycle into the MAC
// DRAIN | waiting for outstanding completions (bounded)
// DONE  | result presented on the valid/ready port
module mac_dot_sequencer #(
  parameter int DEPTH         = 16,
  parameter int AW            = 4,
  parameter int LW            = 5,
  parameter int DRAIN_TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [13:0]   wr_a,
  input  logic [13:0]   wr_b,
  output logic          load_ready,
  input  logic [LW-1:0] len,
  input  logic          start,
  output logic          busy,
  output logic [13:0]   mac_a,
  output logic [13:0]   mac_b,
  output logic          mac_valid_in,
  output logic          mac_clear,
  input  logic [27:0]   mac_f,
  input  logic          mac_valid_out,
  output logic [27:0]   res_data,
  output logic          res_sat,
  output logic          res_err,
  output logic          res_valid,
  input  logic          res_ready
);

  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [27:0] SAT_MAX = 28'h7FF_FFFF;
  localparam logic [27:0] SAT_MIN = 28'h800_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   issue_cnt_q, issue_cnt_d;
  logic [LW-1:0]   done_cnt_q, done_cnt_d;
  logic            clr_cnt_q, clr_cnt_d;
  logic [TW-1:0]   wait_q, wait_d;
  logic [13:0]     mac_a_q, mac_a_d;
  logic [13:0]     mac_b_q, mac_b_d;
  logic            mac_valid_in_q, mac_valid_in_d;
  logic            mac_clear_q, mac_clear_d;
  logic [27:0]     res_data_q, res_data_d;
  logic            res_sat_q, res_sat_d;
  logic            res_err_q, res_err_d;

  logic [13:0]     mem_a_q [DEPTH];
  logic [13:0]     mem_b_q [DEPTH];

  logic [LW-1:0]   len_clamped;
  logic [LW:0]     done_inc;
  logic            done_reached;
  logic            f_is_sat;

  assign len_clamped  = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
  assign done_inc     = {1'b0, done_cnt_q} + (LW + 1)'(mac_valid_out);
  assign done_reached = (done_inc >= {1'b0, len_q});
  assign f_is_sat     = (mac_f == SAT_MAX) || (mac_f == SAT_MIN);

  // Operand storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == S_IDLE)) begin
      mem_a_q[wr_addr] <= wr_a;
      mem_b_q[wr_addr] <= wr_b;
    end
  end

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    issue_cnt_d    = issue_cnt_q;
    done_cnt_d     = done_cnt_q;
    clr_cnt_d      = clr_cnt_q;
    wait_d         = wait_q;
    mac_a_d        = mac_a_q;
    mac_b_d        = mac_b_q;
    mac_valid_in_d = 1'b0;
    res_data_d     = res_data_q;
    res_sat_d      = res_sat_q;
    res_err_d      = res_err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d = len_clamped;
          if (len_clamped == '0) begin
            res_data_d = '0;
            res_sat_d  = 1'b0;
            res_err_d  = 1'b0;
            state_d    = S_DONE;
          end else begin
            clr_cnt_d = 1'b1;
            state_d   = S_CLEAR;
          end
        end
      end

      S_CLEAR: begin
        issue_cnt_d = '0;
        done_cnt_d  = '0;
        if (clr_cnt_q) begin
          clr_cnt_d = 1'b0;
        end else begin
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        mac_valid_in_d = 1'b1;
        mac_a_d        = mem_a_q[issue_cnt_q[AW-1:0]];
        mac_b_d        = mem_b_q[issue_cnt_q[AW-1:0]];
        issue_cnt_d    = issue_cnt_q + LW'(1);
        done_cnt_d     = done_inc[LW-1:0];
        if (issue_cnt_q == (len_q - LW'(1))) begin
          wait_d  = TW'(DRAIN_TIMEOUT - 1);
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        done_cnt_d = done_inc[LW-1:0];
        if (done_reached) begin
          res_data_d = mac_f;
          res_sat_d  = f_is_sat;
          res_err_d  = 1'b0;
          state_d    = S_DONE;
        end else if (wait_q == '0) begin
          // Give up on missing completions but still report what the MAC holds.
          res_data_d = mac_f;
          res_sat_d  = f_is_sat;
          res_err_d  = 1'b1;
          state_d    = S_DONE;
        end else begin
          wait_d = wait_q - TW'(1);
        end
      end

      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    mac_clear_d = (state_d == S_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      issue_cnt_q    <= '0;
      done_cnt_q     <= '0;
      clr_cnt_q      <= 1'b0;
      wait_q         <= '0;
      mac_a_q        <= '0;
      mac_b_q        <= '0;
      mac_valid_in_q <= 1'b0;
      mac_clear_q    <= 1'b1;
      res_data_q     <= '0;
      res_sat_q      <= 1'b0;
      res_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      issue_cnt_q    <= issue_cnt_d;
      done_cnt_q     <= done_cnt_d;
      clr_cnt_q      <= clr_cnt_d;
      wait_q         <= wait_d;
      mac_a_q        <= mac_a_d;
      mac_b_q        <= mac_b_d;
      mac_valid_in_q <= mac_valid_in_d;
      mac_clear_q    <= mac_clear_d;
      res_data_q     <= res_data_d;
      res_sat_q      <= res_sat_d;
      res_err_q      <= res_err_d;
    end
  end

  assign load_ready   = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign res_valid    = (state_q == S_DONE);
  assign mac_a        = mac_a_q;
  assign mac_b        = mac_b_q;
  assign mac_valid_in = mac_valid_in_q;
  assign mac_clear    = mac_clear_q;
  assign res_data     = res_data_q;
  assign res_sat      = res_sat_q;
  assign res_err      = res_err_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Self-checking bench for mac_dot_sequencer with a behavioural saturating MAC
// and a reference dot-product model.
module tb_mac_dot_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [13:0] wr_a, wr_b;
  logic        load_ready;
  logic [4:0]  len;
  logic        start;
  logic        busy;
  logic [13:0] mac_a, mac_b;
  logic        mac_valid_in, mac_clear;
  logic [27:0] mac_f;
  logic        mac_valid_out;
  logic [27:0] res_data;
  logic        res_sat, res_err, res_valid, res_ready;

  int checks = 0;
  int errors = 0;
  int ref_a [16];
  int ref_b [16];
  int clear_cyc = 0;
  int vin_cyc = 0;
  logic drop_req = 1'b0;

  always #5 clk = ~clk;

  mac_dot_sequencer dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_a(wr_a), .wr_b(wr_b), .load_ready(load_ready), .len(len),
    .start(start), .busy(busy), .mac_a(mac_a), .mac_b(mac_b),
    .mac_valid_in(mac_valid_in), .mac_clear(mac_clear), .mac_f(mac_f),
    .mac_valid_out(mac_valid_out), .res_data(res_data), .res_sat(res_sat),
    .res_err(res_err), .res_valid(res_valid), .res_ready(res_ready)
  );

  function automatic longint sat28(input longint v);
    if (v > 134217727) return 134217727;
    if (v < -134217728) return -134217728;
    return v;
  endfunction

  // Saturating MAC: a pair presented in cycle k is accumulated and flagged in cycle k+2.
  logic               m_v1, m_vout, dropped;
  logic signed [27:0] m_p1, m_acc;
  always @(posedge clk) begin
    if (mac_clear) begin
      m_v1 <= 1'b0; m_vout <= 1'b0; m_acc <= '0; m_p1 <= '0; dropped <= 1'b0;
    end else begin
      m_v1 <= mac_valid_in;
      m_p1 <= 28'(longint'($signed(mac_a)) * longint'($signed(mac_b)));
      if (m_v1) m_acc <= 28'(sat28(longint'(m_acc) + longint'(m_p1)));
      m_vout <= m_v1 && !(drop_req && !dropped);
      if (m_v1 && drop_req && !dropped) dropped <= 1'b1;
      if (!drop_req) dropped <= 1'b0;
    end
  end
  assign mac_f         = m_acc;
  assign mac_valid_out = m_vout;

  always @(posedge clk) begin
    if (mac_clear === 1'b1) clear_cyc++;
    if (mac_valid_in === 1'b1) vin_cyc++;
  end

  function automatic longint exp_dot(input int n);
    longint acc = 0;
    for (int i = 0; i < n; i++) acc = sat28(acc + longint'(ref_a[i]) * longint'(ref_b[i]));
    return acc;
  endfunction

  task automatic load(input int addr, input int a, input int b);
    wr_en = 1'b1; wr_addr = 4'(addr); wr_a = 14'(a); wr_b = 14'(b);
    ref_a[addr] = a; ref_b[addr] = b;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic run(input logic [4:0] l, output int cyc, output bit to);
    len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    to = (res_valid !== 1'b1);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; wr_en = 1'b0; start = 1'b0; res_ready = 1'b0; len = '0;
    wr_addr = '0; wr_a = '0; wr_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rst_load_ready got %b exp 1", load_ready); end
    checks++; if (mac_clear !== 1'b1) begin errors++; $display("FAIL rst_mac_clear got %b exp 1", mac_clear); end
    checks++; if (mac_valid_in !== 1'b0) begin errors++; $display("FAIL rst_valid_in got %b exp 0", mac_valid_in); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b exp 0", res_valid); end
    checks++; if (res_data !== 28'd0) begin errors++; $display("FAIL rst_res_data got %0h exp 0", res_data); end
    checks++; if ({res_sat, res_err} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b exp 00", {res_sat, res_err}); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (mac_clear !== 1'b0) begin errors++; $display("FAIL idle_mac_clear got %b exp 0", mac_clear); end
  endtask

  task automatic test_basic();
    int cyc, cb, vb; bit to;
    load(0, 1, 4); load(1, 2, 5); load(2, 3, 6);
    cb = clear_cyc; vb = vin_cyc;
    run(5'd3, cyc, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got no res_valid exp res_valid"); end
    checks++; if (cyc != 8) begin errors++; $display("FAIL basic_latency got %0d exp 8", cyc); end
    checks++; if (res_data !== 28'd32) begin errors++; $display("FAIL basic_data got %0d exp 32", $signed(res_data)); end
    checks++; if ({res_sat, res_err} !== 2'b00) begin errors++; $display("FAIL basic_flags got %b exp 00", {res_sat, res_err}); end
    checks++; if (clear_cyc - cb != 2) begin errors++; $display("FAIL basic_clear_cycles got %0d exp 2", clear_cyc - cb); end
    checks++; if (vin_cyc - vb != 3) begin errors++; $display("FAIL basic_issue_cycles got %0d exp 3", vin_cyc - vb); end
    checks++; if ({busy, load_ready} !== 2'b10) begin errors++; $display("FAIL basic_done_status got %b exp 10", {busy, load_ready}); end
    accept();
    checks++; if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL basic_after_accept got %b exp 00", {res_valid, busy}); end
  endtask

  task automatic test_start_with_write();
    int cyc; bit to;
    load(0, -7, 9); load(1, 300, -11);
    wr_en = 1'b1; wr_addr = 4'd2; wr_a = 14'(1234); wr_b = 14'(-56);
    ref_a[2] = 1234; ref_b[2] = -56;
    run(5'd3, cyc, to);
    wr_en = 1'b0;
    checks++; if (to || res_data !== 28'(exp_dot(3))) begin errors++; $display("FAIL start_write_data got %0d exp %0d", $signed(res_data), exp_dot(3)); end
    accept();
  endtask

  task automatic test_saturation();
    int cyc; bit to;
    for (int i = 0; i < 3; i++) load(i, 8191, 8191);
    run(5'd3, cyc, to);
    checks++; if (to || res_data !== 28'h7FF_FFFF) begin errors++; $display("FAIL sat_pos_data got %0d exp 134217727", $signed(res_data)); end
    checks++; if (res_sat !== 1'b1) begin errors++; $display("FAIL sat_pos_flag got %b exp 1", res_sat); end
    accept();
    for (int i = 0; i < 3; i++) load(i, -8192, 8191);
    run(5'd3, cyc, to);
    checks++; if (to || res_data !== 28'h800_0000) begin errors++; $display("FAIL sat_neg_data got %0d exp -134217728", $signed(res_data)); end
    checks++; if (res_sat !== 1'b1) begin errors++; $display("FAIL sat_neg_flag got %b exp 1", res_sat); end
    accept();
  endtask

  task automatic test_len_edges();
    int cyc, cb, vb; bit to;
    cb = clear_cyc; vb = vin_cyc;
    run(5'd0, cyc, to);
    checks++; if (to || cyc != 0) begin errors++; $display("FAIL len0_latency got %0d exp 0", cyc); end
    checks++; if (res_data !== 28'd0 || {res_sat, res_err} !== 2'b00) begin errors++; $display("FAIL len0_result got %0d/%b exp 0/00", $signed(res_data), {res_sat, res_err}); end
    accept();
    repeat (4) @(posedge clk);
    #1;
    checks++; if (vin_cyc - vb != 0 || clear_cyc - cb != 0) begin errors++; $display("FAIL len0_mac_activity got %0d/%0d exp 0/0", vin_cyc - vb, clear_cyc - cb); end
    for (int i = 0; i < 16; i++) load(i, int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 400)) - 200);
    vb = vin_cyc;
    run(5'd20, cyc, to);
    checks++; if (to || cyc != 21) begin errors++; $display("FAIL clamp_latency got %0d exp 21", cyc); end
    checks++; if (vin_cyc - vb != 16) begin errors++; $display("FAIL clamp_issue_cycles got %0d exp 16", vin_cyc - vb); end
    checks++; if (res_data !== 28'(exp_dot(16))) begin errors++; $display("FAIL clamp_data got %0d exp %0d", $signed(res_data), exp_dot(16)); end
    accept();
  endtask

  task automatic test_hold_done();
    int cyc; bit to;
    for (int i = 0; i < 4; i++) load(i, 10 + i, 20 + i);
    run(5'd4, cyc, to);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        start = 1'b1; len = 5'd1;
        wr_en = 1'b1; wr_addr = 4'd0; wr_a = 14'd1000; wr_b = 14'd1000;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      @(posedge clk); #1;
      checks++; if (res_valid !== 1'b1 || res_data !== 28'(exp_dot(4))) begin errors++; $display("FAIL hold_stable cycle %0d got %b/%0d exp 1/%0d", k, res_valid, $signed(res_data), exp_dot(4)); end
    end
    start = 1'b0; wr_en = 1'b0;
    accept();
    run(5'd4, cyc, to);
    checks++; if (to || res_data !== 28'(exp_dot(4))) begin errors++; $display("FAIL hold_buffer_intact got %0d exp %0d", $signed(res_data), exp_dot(4)); end
    accept();
  endtask

  task automatic test_drop_timeout();
    int cyc; bit to;
    for (int i = 0; i < 3; i++) load(i, 100 * (i + 1), -3 - i);
    drop_req = 1'b1;
    run(5'd3, cyc, to);
    drop_req = 1'b0;
    checks++; if (to || cyc != 13) begin errors++; $display("FAIL drop_latency got %0d exp 13", cyc); end
    checks++; if (res_err !== 1'b1) begin errors++; $display("FAIL drop_err got %b exp 1", res_err); end
    checks++; if (res_data !== 28'(exp_dot(3))) begin errors++; $display("FAIL drop_data got %0d exp %0d", $signed(res_data), exp_dot(3)); end
    accept();
  endtask

  task automatic test_reset_mid();
    int cyc; bit to, seen;
    for (int i = 0; i < 6; i++) load(i, int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000);
    len = 5'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if ({busy, mac_clear, mac_valid_in, res_valid} !== 4'b0100) begin errors++; $display("FAIL midrst_state got %b exp 0100", {busy, mac_clear, mac_valid_in, res_valid}); end
    reset = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (res_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midrst_no_result got activity exp none"); end
    run(5'd6, cyc, to);
    checks++; if (to || cyc != 11 || res_data !== 28'(exp_dot(6))) begin errors++; $display("FAIL midrst_rerun got %0d in %0d cyc exp %0d in 11", $signed(res_data), cyc, exp_dot(6)); end
    accept();
  endtask

  task automatic test_back_to_back();
    int cyc, n, l; bit to; longint e; logic exp_sat;
    for (int it = 0; it < 10; it++) begin
      l = (it % 4 == 3) ? int'($urandom_range(17, 31)) : int'($urandom_range(1, 16));
      n = (l > 16) ? 16 : l;
      for (int i = 0; i < n; i++) begin
        int va, vb;
        va = int'($urandom_range(0, 16383)); vb = int'($urandom_range(0, 16383));
        load(i, (va >= 8192) ? va - 16384 : va, (vb >= 8192) ? vb - 16384 : vb);
      end
      e = exp_dot(n);
      exp_sat = (e == 134217727) || (e == -134217728);
      run(5'(l), cyc, to);
      checks++; if (to || cyc != n + 5) begin errors++; $display("FAIL b2b_latency it %0d got %0d exp %0d", it, cyc, n + 5); end
      checks++; if (res_data !== 28'(e) || res_sat !== exp_sat || res_err !== 1'b0) begin errors++; $display("FAIL b2b_result it %0d got %0d/%b/%b exp %0d/%b/0", it, $signed(res_data), res_sat, res_err, e, exp_sat); end
      accept();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_with_write();
    test_saturation();
    test_len_edges();
    test_hold_done();
    test_drop_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion exp completion");
    $fatal(1, "watchdog");
  end

endmodule
